// File: rtl/dhp_link_aligner.sv
// dhp_link_aligner: per-channel word aligner for the DHP offset-data lines.
// Each channel slides a DES_W-bit window across two consecutive deserialized
// words until it sees TRAIN_PATTERN, confirms it LOCK_CNT times, then locks.
// Optional feature macro: LINK_ERR_CNT_EN (per-channel 8-bit error counters).
module dhp_link_aligner #(
  parameter int N_CH = 16,
  parameter int DES_W = 4,
  parameter logic [DES_W-1:0] TRAIN_PATTERN = 4'b0011,
  parameter int LOCK_CNT = 64,
  parameter int MAX_SWEEPS = 8,
  localparam int OW = $clog2(DES_W)
) (
  input  logic                    CLK_80,
  input  logic                    RST_N,
  input  logic                    TRAIN,
  input  logic [N_CH*DES_W-1:0]   DI_DES,
  input  logic [N_CH-1:0]         CH_DISABLE,
  output logic [N_CH*DES_W-1:0]   DI_ALIGNED,
  output logic [N_CH-1:0]         ALIGNED,
  output logic [N_CH-1:0]         FAILED,
  output logic                    ALL_ALIGNED,
  output logic [N_CH*OW-1:0]      OFFSET,
  output logic [N_CH*8-1:0]       ERR_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  logic            train_q;
  logic            rise;
  logic [N_CH-1:0] aligned_vec_d;
  logic            all_aligned_q;
  logic            all_aligned_d;

  assign rise = TRAIN & ~train_q;

  // Remember the previous TRAIN level so a rising edge restarts alignment.
  always_ff @(posedge CLK_80 or negedge RST_N) begin
    if (!RST_N) begin
      train_q <= 1'b0;
    end else begin
      train_q <= TRAIN;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DES_W-1:0]   din;
    logic [DES_W-1:0]   prev_q;
    logic [2*DES_W-1:0] window;
    logic [DES_W-1:0]   slice;
    logic               match;
    logic               dis;
    state_t             state_q, state_d;
    logic [OW-1:0]      off_q, off_d, off_adv;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         sweep_q, sweep_d, sweep_adv;
    logic               aligned_q, aligned_d;
    logic               failed_q, failed_d;
    logic [DES_W-1:0]   dout_q, dout_d;

    assign din    = DI_DES[k*DES_W +: DES_W];
    assign dis    = CH_DISABLE[k];
    assign window = {prev_q, din};
    // A larger offset picks bits further toward the newer word.
    assign slice  = DES_W'(window >> (DES_W - int'(off_q)));
    assign match  = (slice == TRAIN_PATTERN);

    assign off_adv   = (off_q == OW'(DES_W - 1)) ? '0 : off_q + OW'(1);
    assign sweep_adv = (off_q == OW'(DES_W - 1)) ? sweep_q + 4'd1 : sweep_q;

    // State register plus the offset/confirm/sweep counters it owns.
    always_ff @(posedge CLK_80 or negedge RST_N) begin
      if (!RST_N) begin
        prev_q  <= '0;
        state_q <= ST_IDLE;
        off_q   <= '0;
        cnt_q   <= '0;
        sweep_q <= '0;
      end else begin
        prev_q  <= din;
        state_q <= state_d;
        off_q   <= off_d;
        cnt_q   <= cnt_d;
        sweep_q <= sweep_d;
      end
    end

    // Next-state logic: disable beats a training edge, which beats everything else.
    always_comb begin
      state_d = state_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      sweep_d = sweep_q;
      if (dis) begin
        state_d = ST_IDLE;
        off_d   = '0;
        cnt_d   = '0;
        sweep_d = '0;
      end else if (rise) begin
        state_d = ST_SEARCH;
        off_d   = '0;
        cnt_d   = '0;
        sweep_d = '0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (TRAIN) begin
              if (match) begin
                state_d = ST_CONFIRM;
                cnt_d   = 8'd1;
              end else begin
                off_d   = off_adv;
                sweep_d = sweep_adv;
                if (sweep_adv == 4'(MAX_SWEEPS)) state_d = ST_FAIL;
              end
            end
          end
          ST_CONFIRM: begin
            if (TRAIN) begin
              if (match) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == 8'(LOCK_CNT)) state_d = ST_LOCKED;
              end else begin
                state_d = ST_SEARCH;
                cnt_d   = '0;
                off_d   = off_adv;
                sweep_d = sweep_adv;
                if (sweep_adv == 4'(MAX_SWEEPS)) state_d = ST_FAIL;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Output decode; a disabled channel shows all zeros.
    always_comb begin
      aligned_d = (state_q == ST_LOCKED) && !dis;
      failed_d  = (state_q == ST_FAIL) && !dis;
      dout_d    = dis ? '0 : slice;
    end

    // Registered per-channel outputs.
    always_ff @(posedge CLK_80 or negedge RST_N) begin
      if (!RST_N) begin
        aligned_q <= 1'b0;
        failed_q  <= 1'b0;
        dout_q    <= '0;
      end else begin
        aligned_q <= aligned_d;
        failed_q  <= failed_d;
        dout_q    <= dout_d;
      end
    end

    assign aligned_vec_d[k]             = aligned_d;
    assign ALIGNED[k]                   = aligned_q;
    assign FAILED[k]                    = failed_q;
    assign DI_ALIGNED[k*DES_W +: DES_W] = dout_q;
    assign OFFSET[k*OW +: OW]           = off_q;

`ifdef LINK_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Count mismatches seen while locked and training, saturating at 255.
    always_comb begin
      err_d = err_q;
      if (dis || rise) begin
        err_d = '0;
      end else if ((state_q == ST_LOCKED) && TRAIN && !match && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end

    // Error counter register.
    always_ff @(posedge CLK_80 or negedge RST_N) begin
      if (!RST_N) begin
        err_q <= '0;
      end else begin
        err_q <= err_d;
      end
    end

    assign ERR_CNT[k*8 +: 8] = err_q;
`else
    assign ERR_CNT[k*8 +: 8] = 8'd0;
`endif
  end

  assign all_aligned_d = (&(aligned_vec_d | CH_DISABLE)) && !(&CH_DISABLE);

  // Summary flag, timed together with the per-channel ALIGNED bits.
  always_ff @(posedge CLK_80 or negedge RST_N) begin
    if (!RST_N) begin
      all_aligned_q <= 1'b0;
    end else begin
      all_aligned_q <= all_aligned_d;
    end
  end

  assign ALL_ALIGNED = all_aligned_q;

endmodule

// File: doc/dhp_link_aligner.md
Name: dhp_link_aligner

Overview:
Parametrised word-alignment stage that sits behind the 1:DES_W input deserializers for the DHP offset-data lines (DIx) and before the DCD-emulator core.
- Per channel, finds the bit offset at which the deserialized stream matches a training pattern, then locks that offset.
- Outputs aligned words and per-channel lock/fail status.
- Generalises the fixed-width deserializer mapping to N_CH channels of DES_W bits and adds training-based alignment, which the fixed mapping lacks.

Parameters:
N_CH, 16, number of deserialized input channels
DES_W, 4, bits per channel per CLK_80 cycle (deserialization ratio, 2..8)
TRAIN_PATTERN, 4'b0011, DES_W-bit training word; all rotations must be distinct
LOCK_CNT, 64, consecutive matching words required to lock (2..255)
MAX_SWEEPS, 8, full offset sweeps without any match before FAIL (1..15)
OW (localparam), clog2(DES_W), offset field width

Ports:
CLK_80  in  1  system clock; all logic on rising edge
RST_N  in  1  reset, asynchronous and active-low
TRAIN  in  1  training mode level; its rising edge restarts alignment
DI_DES  in  N_CH*DES_W  deserialized words; channel k at [k*DES_W +: DES_W]
CH_DISABLE  in  N_CH  per-channel disable
DI_ALIGNED  out  N_CH*DES_W  aligned words, registered
ALIGNED  out  N_CH  channel in LOCKED state
FAILED  out  N_CH  channel in FAIL state
ALL_ALIGNED  out  1  every enabled channel is LOCKED and at least one channel is enabled
OFFSET  out  N_CH*OW  current bit offset per channel
ERR_CNT  out  N_CH*8  per-channel saturating mismatch counters (see Optional Feature)

Behaviour:
- Reset (RST_N low, asynchronous): all outputs and registers go to 0; every FSM enters IDLE; offsets = 0.
- Datapath per channel:
  - prev_q <= DI_DES slice each cycle; window = {prev_q, DI_DES slice} (2*DES_W bits).
  - slice = window[2*DES_W-1-off -: DES_W]; DI_ALIGNED <= slice.
  - At off=0, latency from DI_DES to DI_ALIGNED is 2 cycles. match = (slice == TRAIN_PATTERN).
- TRAIN edge detection: registered TRAIN; rise = TRAIN & !TRAIN_q.
- FSM per channel; states IDLE, SEARCH, CONFIRM, LOCKED, FAIL:
  - Any state, on rise with channel enabled -> SEARCH; off=0, cnt=0, sweep=0, ERR_CNT=0.
  - IDLE: wait for rise.
  - SEARCH, TRAIN high:
    - match -> CONFIRM, cnt=1.
    - Otherwise off <= off+1; on wrap from DES_W-1 to 0, sweep++.
    - When sweep reaches MAX_SWEEPS -> FAIL.
  - CONFIRM, TRAIN high:
    - match -> cnt++; when cnt reaches LOCK_CNT -> LOCKED.
    - Mismatch -> SEARCH, off+1 with the same wrap and sweep rule, cnt=0.
  - SEARCH/CONFIRM with TRAIN low: hold state, off and cnt (frozen).
  - LOCKED: off frozen; ALIGNED=1. A mismatch while TRAIN is high increments ERR_CNT (saturates at 255). The channel never leaves LOCKED except on rise, reset or disable.
  - FAIL: FAILED=1, off held; exits only on rise or reset.
- An offset change takes effect on the slice in the next cycle.
- Disabled channel:
  - FSM forced to IDLE; DI_ALIGNED slice, ALIGNED, FAILED, OFFSET and ERR_CNT are 0.
  - Excluded from ALL_ALIGNED.
  - Re-enabling leaves it in IDLE until the next rise.
- Simultaneous rise and disable on a channel: disable wins.
- ALIGNED, FAILED and ALL_ALIGNED are registered, valid the cycle after the state transition.

Optional Feature:
Macro LINK_ERR_CNT_EN.
- Defined: per-channel 8-bit ERR_CNT counters are implemented as described.
- Undefined: no counter logic; ERR_CNT is tied to 0. All other behaviour is unchanged.

Test Plan:
- RST_N low with random DI_DES and TRAIN -> all outputs 0. Release reset, no TRAIN edge -> FSMs stay IDLE and ALIGNED=0.
- Ch0 fed constant 4'b0110, TRAIN 0->1 -> OFFSET[ch0]=3 after 3 search cycles; ALIGNED[0]=1 within 70 cycles; DI_ALIGNED ch0 = 4'b0011.
- Ch1 fed constant 4'b0000, TRAIN high -> FAILED[1]=1 after 32 cycles (8 sweeps x 4); ALIGNED[1]=0. A new TRAIN rise returns it to SEARCH with OFFSET=0.
- All channels fed aligned pattern, CH_DISABLE=16'h8000 with ch15 fed zeros -> ALL_ALIGNED=1; ch15 outputs all 0.
- Ch0 locked, TRAIN high, one word corrupted to 4'b1111 -> ERR_CNT[ch0]=1 and ALIGNED stays 1. With the macro undefined, ERR_CNT stays 0.
- Ch0 in CONFIRM at cnt=30, RST_N pulsed low mid-cycle -> outputs 0 immediately (asynchronous); after release the FSM is IDLE.
